// File: rtl/spi_master_core_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_master_core_pkg
// Brief  : Shared definitions for the SPI master PHY: FSM state encoding,
//          default field widths, SPI mode constants and frame-length helper.
// Rev    : 1.0  initial release
// ============================================================================
package spi_master_core_pkg;

  // Default field widths and divider setting
  localparam int c_spi_addr_width_def = 6;
  localparam int c_spi_data_width_def = 20;
  localparam int c_clk_div_def        = 2;

  // SPI mode 0: clock idles low, data sampled on the rising edge
  localparam logic c_spi_cpol = 1'b0;
  localparam logic c_spi_cpha = 1'b0;

  // Transaction sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_GAP      = 3'd4
  } spi_state_e;

  // Frame length: one rw bit, then address, then data
  function automatic int frame_bits(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_core_clk_div.sv
`default_nettype none
// ============================================================================
// Module : spi_master_core_clk_div
// Brief  : Free-running divider producing one tick every CLK_DIV cycles while
//          enabled; held at zero when disabled so each frame starts aligned.
// Rev    : 1.0  initial release
// ============================================================================
module spi_master_core_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  // Wrap at CLK_DIV-1; clear whenever the sequencer is idle
  always_comb begin
    cnt_d = cnt_q;
    if (!i_en) begin
      cnt_d = '0;
    end else if (cnt_q == c_cnt_max) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + c_cnt_w'(1);
    end
  end

  // Counter register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_en && (cnt_q == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/spi_master_core.sv
`default_nettype none
// ============================================================================
// Module : spi_master_core
// Brief  : SPI mode-0 master PHY. Takes one rw/address/data request, shifts a
//          framed transaction MSB first, returns read data and a ready level.
// Rev    : 1.0  initial release
// ============================================================================
module spi_master_core
  import spi_master_core_pkg::*;
#(
  parameter int SPI_ADDR_WIDTH = 6,
  parameter int SPI_DATA_WIDTH = 20,
  parameter int CLK_DIV        = 2
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_n,
  input  logic                      i_spi_start,
  input  logic                      i_spi_rw,
  input  logic [SPI_ADDR_WIDTH-1:0] i_spi_write_address,
  input  logic [SPI_DATA_WIDTH-1:0] i_spi_write_data,
  output logic                      o_spi_data_valid,
  output logic [SPI_DATA_WIDTH-1:0] o_spi_read_data,
  output logic                      o_spi_sclk,
  output logic                      o_spi_cs_n,
  output logic                      o_spi_mosi,
  input  logic                      i_spi_miso
);

  localparam int c_frame = frame_bits(SPI_ADDR_WIDTH, SPI_DATA_WIDTH);
  localparam int c_bit_w = $clog2(c_frame);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_frame - 1);

  spi_state_e                state_q, state_d;
  logic                      valid_q, valid_d;
  logic [SPI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      sclk_q, sclk_d;
  logic                      cs_n_q, cs_n_d;
  logic                      mosi_q, mosi_d;
  logic                      rw_q, rw_d;
  logic [c_frame-2:0]        tx_q, tx_d;      // frame bits still to send after mosi
  logic [c_bit_w-1:0]        bit_q, bit_d;
  logic [SPI_DATA_WIDTH-1:0] rx_q, rx_d;
  logic                      miso_s1_q, miso_s1_d;
  logic                      miso_s2_q, miso_s2_d;
  logic                      rise_p1_q, rise_p1_d;
  logic                      rise_p2_q, rise_p2_d;

  logic                      w_tick;
  logic                      w_rise_now;
  logic [SPI_DATA_WIDTH-1:0] w_tx_data;

  spi_master_core_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_rst_n),
    .i_en    (state_q != ST_IDLE),
    .o_tick  (w_tick)
  );

  assign w_rise_now = (state_q == ST_SHIFT) && w_tick && !sclk_q;
  assign w_tx_data  = i_spi_rw ? {SPI_DATA_WIDTH{1'b0}} : i_spi_write_data;

  // MISO sync and delayed rising-edge sampling; header bits shift out the top
  always_comb begin
    miso_s1_d = i_spi_miso;
    miso_s2_d = miso_s1_q;
    rise_p1_d = w_rise_now;
    rise_p2_d = rise_p1_q;
    rx_d      = rx_q;
    if (rise_p2_q) begin
      rx_d = {rx_q[SPI_DATA_WIDTH-2:0], miso_s2_q};
    end
  end

  // Sequencer next state: setup, shift, hold, gap, then report ready
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    rw_d    = rw_q;
    tx_d    = tx_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (i_spi_start && valid_q) begin
          state_d = ST_CS_SETUP;
          valid_d = 1'b0;
          cs_n_d  = 1'b0;
          rw_d    = i_spi_rw;
          mosi_d  = i_spi_rw;
          tx_d    = {i_spi_write_address, w_tx_data};
          bit_d   = c_last_bit;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_CS_SETUP: begin
        if (w_tick) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == '0) begin
              state_d = ST_CS_HOLD;
            end else begin
              bit_d  = bit_q - c_bit_w'(1);
              mosi_d = tx_q[c_frame-2];
              tx_d   = {tx_q[c_frame-3:0], 1'b0};
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (w_tick) begin
          state_d = ST_GAP;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          // rx_d includes a sample still in flight at the fastest divider
          if (rw_q) rdata_d = rx_d;
        end
      end
      ST_GAP: begin
        if (w_tick) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any frame in progress
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b1;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rw_q    <= 1'b0;
      tx_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      rw_q    <= rw_d;
      tx_q    <= tx_d;
      bit_q   <= bit_d;
    end
  end

  // Receive path registers
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      rise_p1_q <= 1'b0;
      rise_p2_q <= 1'b0;
      rx_q      <= '0;
    end else begin
      miso_s1_q <= miso_s1_d;
      miso_s2_q <= miso_s2_d;
      rise_p1_q <= rise_p1_d;
      rise_p2_q <= rise_p2_d;
      rx_q      <= rx_d;
    end
  end

  assign o_spi_data_valid = valid_q;
  assign o_spi_read_data  = rdata_q;
  assign o_spi_sclk       = sclk_q;
  assign o_spi_cs_n       = cs_n_q;
  assign o_spi_mosi       = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_core.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_master_core
// Brief  : Self-checking bench for spi_master_core at CLK_DIV = 2, 1 and 5,
//          with a mode-0 slave / loopback model and a frame reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_spi_master_core;

  localparam int AW = 6;
  localparam int DW = 20;
  localparam int FR = 1 + AW + DW;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start   [NI];
  logic          rw      [NI];
  logic [AW-1:0] addr    [NI];
  logic [DW-1:0] wdata   [NI];
  logic          valid   [NI];
  logic [DW-1:0] rdata   [NI];
  logic          sclk    [NI];
  logic          cs_n    [NI];
  logic          mosi    [NI];
  logic          miso    [NI];

  logic          loop_en [NI];
  logic [FR-1:0] slv_resp[NI];
  logic [DW-1:0] exp_rd  [NI];

  logic [63:0]   mon      [NI];
  int            pulses   [NI] = '{default: 0};
  int            falls    [NI] = '{default: 0};
  int            windows  [NI] = '{default: 0};
  int            t_rise   [NI] = '{default: 0};
  int            gap      [NI] = '{default: 0};
  logic          cs_prev  [NI] = '{default: 1'b1};
  logic          sclk_prev[NI] = '{default: 1'b0};
  int            cyc = 0;

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spi_master_core #(
      .SPI_ADDR_WIDTH (AW),
      .SPI_DATA_WIDTH (DW),
      .CLK_DIV        ((g == 0) ? 2 : ((g == 1) ? 1 : 5))
    ) u_dut (
      .i_clk_sys           (clk),
      .i_rst_n             (rst_n),
      .i_spi_start         (start[g]),
      .i_spi_rw            (rw[g]),
      .i_spi_write_address (addr[g]),
      .i_spi_write_data    (wdata[g]),
      .o_spi_data_valid    (valid[g]),
      .o_spi_read_data     (rdata[g]),
      .o_spi_sclk          (sclk[g]),
      .o_spi_cs_n          (cs_n[g]),
      .o_spi_mosi          (mosi[g]),
      .i_spi_miso          (miso[g])
    );
  end

  // Bus monitor and slave: mosi captured on SCLK rise, miso moves after SCLK fall
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (!cs_n[k] && cs_prev[k]) begin
        windows[k]++;
        gap[k]    = cyc - t_rise[k];
        mon[k]    = '0;
        pulses[k] = 0;
        falls[k]  = 0;
      end
      if (cs_n[k] && !cs_prev[k]) t_rise[k] = cyc;
      if (sclk[k] && !sclk_prev[k]) begin
        mon[k] = {mon[k][62:0], mosi[k]};
        pulses[k]++;
      end
      if (!sclk[k] && sclk_prev[k]) falls[k]++;
      cs_prev[k]   = cs_n[k];
      sclk_prev[k] = sclk[k];
      if (loop_en[k])        miso[k] = mosi[k];
      else if (falls[k] < FR) miso[k] = slv_resp[k][FR-1-falls[k]];
      else                   miso[k] = 1'b0;
    end
  end

  function automatic int div_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for ready, then present a request for exactly one cycle
  task automatic accept(input int k, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (valid[k] !== 1'b1 && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    rw[k] = r; addr[k] = a; wdata[k] = d; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (valid[k] !== 1'b1 && n < 4000);
  endtask

  // One full transaction checked against the frame rules
  task automatic run_frame(input int k, input logic r, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] sd, input logic lp);
    logic [FR-1:0] ef;
    int n;
    ef = {r, a, (r ? {DW{1'b0}} : d)};
    slv_resp[k] = {{(FR-DW){1'b0}}, sd};
    loop_en[k]  = lp;
    accept(k, r, a, d);
    wait_valid(k, n);
    check($sformatf("k%0d_latency", k), 64'(n), 64'(div_of(k) * (2 * FR + 3) + 1));
    check($sformatf("k%0d_sclk_pulses", k), 64'(pulses[k]), 64'(FR));
    check($sformatf("k%0d_mosi_frame", k), 64'(mon[k][FR-1:0]), 64'(ef));
    if (r) exp_rd[k] = lp ? ef[DW-1:0] : sd;
    check($sformatf("k%0d_read_data", k), 64'(rdata[k]), 64'(exp_rd[k]));
  endtask

  initial begin
    int n;
    int w0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic [FR-1:0] ef;

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0; rw[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
      loop_en[k] = 1'b0; slv_resp[k] = '0; exp_rd[k] = '0; mon[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid[0]), 64'(1));
    check("rst_read_data", 64'(rdata[0]), 64'(0));
    check("rst_sclk", 64'(sclk[0]), 64'(0));
    check("rst_cs_n", 64'(cs_n[0]), 64'(1));
    check("rst_mosi", 64'(mosi[0]), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed write, then directed read against the slave model
    run_frame(0, 1'b0, 6'h2A, 20'hABCDE, DW'($urandom), 1'b0);
    run_frame(0, 1'b1, 6'h05, DW'($urandom), 20'h5A5A5, 1'b0);

    // Extra start pulses while the frame is in flight are ignored
    w0 = windows[0];
    ra = AW'($urandom);
    rd = DW'($urandom);
    ef = {1'b0, ra, rd};
    accept(0, 1'b0, ra, rd);
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(3, 15)) @(posedge clk);
      #1;
      rw[0] = 1'($urandom); addr[0] = AW'($urandom); wdata[0] = DW'($urandom);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    wait_valid(0, n);
    check("ign_one_window", 64'(windows[0] - w0), 64'(1));
    check("ign_sclk_pulses", 64'(pulses[0]), 64'(FR));
    check("ign_mosi_frame", 64'(mon[0][FR-1:0]), 64'(ef));
    check("ign_read_data", 64'(rdata[0]), 64'(exp_rd[0]));
    repeat (20) @(posedge clk);
    #1;
    check("ign_no_second_window", 64'(windows[0] - w0), 64'(1));

    // Asynchronous reset at SCLK pulse 13 of a read
    slv_resp[0] = {{(FR-DW){1'b0}}, DW'($urandom)};
    accept(0, 1'b1, AW'($urandom), DW'($urandom));
    @(posedge clk); #1;
    n = 0;
    while (pulses[0] < 13 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("mid_pulse13_reached", 64'(pulses[0] >= 13), 64'(1));
    rst_n = 1'b0;
    #2;
    check("mid_cs_n", 64'(cs_n[0]), 64'(1));
    check("mid_sclk", 64'(sclk[0]), 64'(0));
    check("mid_valid", 64'(valid[0]), 64'(1));
    check("mid_mosi", 64'(mosi[0]), 64'(0));
    check("mid_read_data", 64'(rdata[0]), 64'(0));
    for (int k = 0; k < NI; k++) exp_rd[k] = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0);

    // Back-to-back read then write, each started on the first ready cycle
    run_frame(0, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
    run_frame(0, 1'b0, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
    check("b2b_cs_gap_ge_div", 64'(gap[0] >= div_of(0)), 64'(1));

    // Divider sweep: slave-model read, loopback read, loopback write
    for (int k = 1; k < NI; k++) begin
      run_frame(k, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b0);
      run_frame(k, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom), 1'b1);
      run_frame(k, 1'b0, AW'($urandom), DW'($urandom), DW'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
